// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared pixel/row widths, feeder states and default kernel for the feeder and MAC
package conv_pkg;

    localparam int PIX_W = 8;
    localparam int ROW_W = 3 * PIX_W;

    typedef enum logic [1:0] {
        ACCEPT,
        EMIT0,
        EMIT1,
        EMIT2
    } state_t;

    // Laplacian: row0 in the top 24 bits, left weight in each row's MSB byte
    localparam logic [3*ROW_W-1:0] KERNEL_DEFAULT = 72'hFF_FF_FF_FF_08_FF_FF_FF_FF;

    function automatic logic [ROW_W-1:0] kernel_row(input logic [3*ROW_W-1:0] kernel,
                                                     input int idx);
        return kernel[3*ROW_W-1-idx*ROW_W -: ROW_W];
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - DEPTH-deep shift-on-enable delay line; tap is the sample DEPTH enables ago
module conv_line_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; valid data is refilled before it is ever used.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign tap = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - raster pixels in, three row beats per interior 3x3 window out
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int                  IMG_W  = 8,
    parameter logic [3*ROW_W-1:0]  KERNEL = KERNEL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [ROW_W-1:0] data,
    output logic [ROW_W-1:0] weight,
    output logic             win_valid,
    output logic             win_first,
    output logic             busy
);

    localparam int COL_W = $clog2(IMG_W);

    state_t           state;
    state_t           state_next;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] cur_col;
    logic [COL_W-1:0] col_next;
    logic [1:0]       row;
    logic [1:0]       cur_row;
    logic [1:0]       row_next;
    logic             accept;
    logic             col_wrap;
    logic             complete;
    logic [PIX_W-1:0] tap_mid;
    logic [PIX_W-1:0] tap_top;
    logic [ROW_W-1:0] top_row;
    logic [ROW_W-1:0] mid_row;
    logic [ROW_W-1:0] bot_row;
    logic [ROW_W-1:0] top_next;
    logic [ROW_W-1:0] mid_next;
    logic [ROW_W-1:0] bot_next;
    logic [ROW_W-1:0] data_next;
    logic [ROW_W-1:0] weight_next;
    logic             valid_next;
    logic             first_next;

    assign accept = pix_valid & pix_ready;

    // sof re-anchors the accepted pixel at (0,0) before the window test
    assign cur_col  = sof ? '0 : col;
    assign cur_row  = sof ? '0 : row;
    assign col_wrap = (cur_col == COL_W'(IMG_W - 1));
    assign col_next = col_wrap ? '0 : cur_col + COL_W'(1);
    assign row_next = (col_wrap && cur_row != 2'd2) ? cur_row + 2'd1 : cur_row;
    assign complete = accept && (cur_row >= 2'd2) && (cur_col >= COL_W'(2));

    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_mid (
        .clk (clk),
        .en  (accept),
        .din (pix_in),
        .tap (tap_mid)
    );

    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_top (
        .clk (clk),
        .en  (accept),
        .din (tap_mid),
        .tap (tap_top)
    );

    assign top_next = {top_row[ROW_W-PIX_W-1:0], tap_top};
    assign mid_next = {mid_row[ROW_W-PIX_W-1:0], tap_mid};
    assign bot_next = {bot_row[ROW_W-PIX_W-1:0], pix_in};

    always_comb begin
        state_next = state;
        case (state)
            ACCEPT:  if (complete) state_next = EMIT0;
            EMIT0:   state_next = EMIT1;
            EMIT1:   state_next = EMIT2;
            EMIT2:   state_next = ACCEPT;
            default: state_next = ACCEPT;
        endcase
    end

    // No accepts happen while emitting, so the window regs double as the snapshot
    // taken at the completing accept and stay stable across all three beats.
    always_comb begin
        data_next   = '0;
        weight_next = '0;
        valid_next  = 1'b0;
        first_next  = 1'b0;
        case (state_next)
            EMIT0: begin
                data_next   = top_next;
                weight_next = kernel_row(KERNEL, 0);
                valid_next  = 1'b1;
                first_next  = 1'b1;
            end
            EMIT1: begin
                data_next   = mid_row;
                weight_next = kernel_row(KERNEL, 1);
                valid_next  = 1'b1;
            end
            EMIT2: begin
                data_next   = bot_row;
                weight_next = kernel_row(KERNEL, 2);
                valid_next  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ACCEPT;
            col       <= '0;
            row       <= '0;
            top_row   <= '0;
            mid_row   <= '0;
            bot_row   <= '0;
            data      <= '0;
            weight    <= '0;
            win_valid <= 1'b0;
            win_first <= 1'b0;
            busy      <= 1'b0;
            pix_ready <= 1'b0;
        end else begin
            state     <= state_next;
            data      <= data_next;
            weight    <= weight_next;
            win_valid <= valid_next;
            win_first <= first_next;
            busy      <= valid_next;
            pix_ready <= (state_next == ACCEPT);
            if (accept) begin
                col     <= col_next;
                row     <= row_next;
                top_row <= top_next;
                mid_row <= mid_next;
                bot_row <= bot_next;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb/tb_conv_window_feeder.sv - self-checking bench for conv_window_feeder with IMG_W=4
module tb_conv_window_feeder;

    localparam int W = 4;
    localparam logic [71:0] K = 72'hFF_FF_FF_FF_08_FF_FF_FF_FF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sof = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [23:0] data;
    logic [23:0] weight;
    logic        win_valid;
    logic        win_first;
    logic        busy;

    conv_window_feeder #(.IMG_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sof       (sof),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .data      (data),
        .weight    (weight),
        .win_valid (win_valid),
        .win_first (win_first),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] d;
        logic [23:0] w;
        logic        f;
    } beat_t;

    int    checks = 0;
    int    fails = 0;
    int    ready_low = 0;
    int    mrow = 0;
    int    mcol = 0;
    bit    armed = 0;
    bit    took = 0;
    logic [7:0] hist [$];
    beat_t expq [$];
    beat_t seen [$];
    beat_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] krow(input int r);
        logic [71:0] k;
        k = K;
        return k[71-24*r -: 24];
    endfunction

    // Reference: flat history of accepted pixels; the window for pixel n is read back
    // from positions one and two lines earlier.
    task automatic model_accept();
        int r, c, n, base;
        beat_t b;
        r = sof ? 0 : mrow;
        c = sof ? 0 : mcol;
        hist.push_back(pix_in);
        n = hist.size();
        if (r >= 2 && c >= 2) begin
            for (int k = 0; k < 3; k++) begin
                base = n - 1 - (2 - k) * W - 2;
                b.d = {hist[base], hist[base+1], hist[base+2]};
                b.w = krow(k);
                b.f = (k == 0);
                expq.push_back(b);
            end
        end
        c++;
        if (c == W) begin
            c = 0;
            if (r < 2) r++;
        end
        mrow = r;
        mcol = c;
        took = 1;
    endtask

    task automatic cycle();
        beat_t e;
        @(negedge clk);
        if (!rst) begin
            expq.delete();
            hist.delete();
            mrow = 0;
            mcol = 0;
            armed = 0;
            check("rst_outputs", {pix_ready, win_valid, win_first, busy, data, weight}, '0);
        end else begin
            e = (expq.size() != 0) ? expq[0] : '0;
            check("data", data, e.d);
            check("weight", weight, e.w);
            check("win_valid", win_valid, expq.size() != 0);
            check("win_first", win_first, e.f);
            check("busy", busy, expq.size() != 0);
            check("pix_ready", pix_ready, armed && expq.size() == 0);
            if (win_valid) seen.push_back({data, weight, win_first});
            if (!pix_ready) ready_low++;
            if (expq.size() != 0) void'(expq.pop_front());
            else if (armed && pix_valid) model_accept();
            armed = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p, input logic s);
        int guard;
        guard = 0;
        pix_valid = 1'b1;
        pix_in = p;
        sof = s;
        took = 0;
        while (!took && guard < 10) begin
            cycle();
            guard++;
        end
        check("send_accepted", took, 1'b1);
        sof = 1'b0;
    endtask

    task automatic flush();
        pix_valid = 1'b0;
        repeat (5) cycle();
    endtask

    initial begin
        tbl[0]  = {24'h010203, 24'hFFFFFF, 1'b1};
        tbl[1]  = {24'h050607, 24'hFF08FF, 1'b0};
        tbl[2]  = {24'h090A0B, 24'hFFFFFF, 1'b0};
        tbl[3]  = {24'h020304, 24'hFFFFFF, 1'b1};
        tbl[4]  = {24'h060708, 24'hFF08FF, 1'b0};
        tbl[5]  = {24'h0A0B0C, 24'hFFFFFF, 1'b0};
        tbl[6]  = {24'h050607, 24'hFFFFFF, 1'b1};
        tbl[7]  = {24'h090A0B, 24'hFF08FF, 1'b0};
        tbl[8]  = {24'h0D0E0F, 24'hFFFFFF, 1'b0};
        tbl[9]  = {24'h060708, 24'hFFFFFF, 1'b1};
        tbl[10] = {24'h0A0B0C, 24'hFF08FF, 1'b0};
        tbl[11] = {24'h0E0F10, 24'hFFFFFF, 1'b0};

        // reset held 3 cycles, then release
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        cycle();

        // full 4x4 frame, pix_valid held high
        seen.delete();
        ready_low = 0;
        for (int p = 1; p <= 16; p++) send(8'(p), p == 1);
        flush();
        check("window_beats", seen.size(), 12);
        check("ready_low_cycles", ready_low, 12);
        for (int i = 0; i < 12 && i < seen.size(); i++) begin
            check($sformatf("tbl_beat%0d", i), seen[i], tbl[i]);
        end

        // reset during EMIT1 aborts the window; counters restart at row 0
        seen.delete();
        for (int p = 1; p <= 11; p++) send(8'(p), p == 1);
        pix_valid = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        for (int p = 12; p <= 16; p++) send(8'(p), 1'b0);
        flush();
        check("abort_beats", seen.size(), 1);

        // sof mid-frame restarts the counters
        seen.delete();
        for (int p = 1; p <= 16; p++) send(8'(p), p == 1 || p == 7);
        check("restart_no_window", seen.size(), 0);
        send(8'd17, 1'b0);
        flush();
        check("restart_window", seen.size(), 3);

        // randomized traffic with occasional sof and reset
        for (int i = 0; i < 3000; i++) begin
            pix_valid = ($urandom_range(0, 9) < 7);
            pix_in = 8'($urandom);
            sof = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst = 1'b1;
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
